alu_exec_ctrl: RTL
==================

Name: alu_exec_ctrl

Overview:
- Execute-stage controller that sits directly upstream of alu_sch and consumes its result.
- Accepts one 16-bit instruction at a time and reads operands from an internal 4x8 register file.
- Drives registered X, Y and SEL into the ALU, then writes DATA_OUT and Cnext back to the register file and carry flag.
- Provides the sequencing the combinational ALU lacks in the toy processor datapath.

Parameters:
- DW, 8, datapath width; matches ALU X/Y/DATA_OUT.
- NREG, 4, register count; fixed by the 2-bit register fields.

Ports:
- CLK  in  1  single clock, rising-edge.
- RST_N  in  1  synchronous reset, active-low, sampled on rising CLK.
- INSTR_VALID  in  1  instruction present.
- INSTR  in  16  bits [15:14] OP, [13:12] RD, [11:10] RA, [9:8] RB, [7:0] IMM.
- INSTR_READY  out  1  high only in IDLE.
- X  out  DW  ALU operand A, registered.
- Y  out  DW  ALU operand B, registered.
- SEL  out  1  ALU function select, registered.
- DATA_OUT  in  DW  ALU result, combinational from X/Y/SEL.
- Cnext  in  1  ALU carry out.
- C_FLAG  out  1  registered carry from the last ALU op.
- DONE  out  1  one-cycle pulse when an instruction retires.
- RD_SEL  in  2  debug register read select.
- RD_DATA  out  DW  R[RD_SEL], combinational.

Behaviour:
- Reset (RST_N=0 at an edge):
  - State goes to IDLE; R0..R3 = 0; X = Y = 0; SEL = 0; C_FLAG = 0; DONE = 0; IR cleared.
  - Reset wins over every other event, including mid-EXEC or mid-WB; the in-flight instruction is dropped with no write.
- Opcodes:
  - 00 LOADI: R[RD] <= IMM.
  - 01 ALU with SEL=0.
  - 10 ALU with SEL=1.
  - 11 NOP.
- State machine: IDLE, EXEC, WB.
  - IDLE: INSTR_READY=1. On an edge with INSTR_VALID=1, latch INSTR into IR.
    - ALU op: load X <= R[RA], Y <= R[RB], SEL <= OP[1] (01 gives 0, 10 gives 1); go to EXEC.
    - LOADI or NOP: go to WB; X, Y, SEL unchanged.
  - EXEC: INSTR_READY=0. X, Y and SEL are held stable for one full cycle so the ALU settles. At the next edge capture RES <= DATA_OUT and CAP_C <= Cnext; go to WB.
  - WB: INSTR_READY=0; DONE=1 for exactly this cycle, decoded from state.
    - At the WB->IDLE edge: ALU op writes R[RD] <= RES and C_FLAG <= CAP_C; LOADI writes R[RD] <= IMM with C_FLAG unchanged; NOP writes nothing.
- Latency, counted from the accept edge:
  - ALU op: 3 cycles to the next INSTR_READY; DONE asserted in the 2nd cycle after accept.
  - LOADI/NOP: 2 cycles; DONE asserted in the 1st cycle after accept.
- Hazards: the write completes before IDLE is re-entered, so back-to-back dependent instructions read the new value. No forwarding required.
- RD=RA or RD=RB is legal; operands are sampled at accept, before the write.
- INSTR_VALID outside IDLE is ignored. INSTR may change freely after accept because IR holds the instruction.
- X, Y and SEL keep their last values outside EXEC; the ALU output is ignored outside EXEC.
- Arithmetic is performed entirely by alu_sch. This block never modifies DATA_OUT; the 8-bit result wraps inside the ALU and carry is reported only via Cnext.
- RD_DATA reflects a write starting the cycle after the WB edge.

Test Plan:
- The bench ALU model is SEL=0 -> {Cnext,DATA_OUT}=X+Y and SEL=1 -> X-Y with Cnext=borrow.
- Reset then idle: after RST_N low for 2 edges, RD_DATA = 0x00 for all RD_SEL; INSTR_READY=1, DONE=0, C_FLAG=0.
- LOADI R1=0x25 then LOADI R2=0x3A: DONE pulses 1 cycle after each accept; RD_DATA(1)=0x25, RD_DATA(2)=0x3A; X/Y unchanged.
- ALU SEL=0 with RD=3, RA=1, RB=2: X=0x25, Y=0x3A and SEL=0 during EXEC; R3=0x5F; C_FLAG=0; DONE 2 cycles after accept.
- Carry and wrap: LOADI R0=0xF0, then ALU SEL=0 with RD=0, RA=0, RB=2 -> R0=0x2A, C_FLAG=1. A following NOP gives DONE with C_FLAG still 1 and no register change.
- INSTR_VALID held high continuously with 4 queued instructions: exactly one accept per IDLE cycle and INSTR_READY low in EXEC/WB. A dependent ALU op immediately after a LOADI reads the new value.
- RST_N pulsed low during EXEC of ALU R3 <- R1,R2: R3 stays 0x00, DONE never pulses, next cycle is IDLE with all outputs at reset values.

Source files
------------

// File: rtl/alu_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : alu_exec_ctrl_if
// Brief  : Instruction handshake, ALU operand/result bus and debug read port
// Rev    : 1.0  initial release
// ============================================================================
interface alu_exec_ctrl_if #(
    parameter int DW = 8
);
    logic          instr_valid;
    logic [15:0]   instr;
    logic          instr_ready;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic          sel;
    logic [DW-1:0] data_out;
    logic          cnext;
    logic          c_flag;
    logic          done;
    logic [1:0]    rd_sel;
    logic [DW-1:0] rd_data;

    modport slave (
        input  instr_valid, instr, data_out, cnext, rd_sel,
        output instr_ready, x, y, sel, c_flag, done, rd_data
    );

    modport master (
        output instr_valid, instr, data_out, cnext, rd_sel,
        input  instr_ready, x, y, sel, c_flag, done, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module : alu_exec_ctrl
// Brief  : Execute-stage sequencer feeding a combinational ALU from a 4x8 RF
// Rev    : 1.0  initial release
// ============================================================================
module alu_exec_ctrl #(
    parameter int DW   = 8,
    parameter int NREG = 4
) (
    input  wire logic          clk_i,
    input  wire logic          rst_n_i,
    alu_exec_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;

    state_t        state_q, state_d;
    logic [1:0]    op_q;
    logic [1:0]    rd_q;
    logic [7:0]    imm_q;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] x_q, y_q, res_q;
    logic          sel_q, c_flag_q, cap_c_q;

    logic [1:0]    w_op_in;
    logic          w_in_is_alu;
    logic          w_accept;
    logic          w_op_is_alu;

    assign w_op_in     = bus.instr[15:14];
    assign w_in_is_alu = (w_op_in == OP_ADD) || (w_op_in == OP_SUB);
    assign w_accept    = (state_q == ST_IDLE) && bus.instr_valid;
    assign w_op_is_alu = (op_q == OP_ADD) || (op_q == OP_SUB);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.instr_valid) state_d = w_in_is_alu ? ST_EXEC : ST_WB;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands are sampled at accept, so RD may alias RA/RB safely.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            sel_q    <= 1'b0;
            res_q    <= '0;
            cap_c_q  <= 1'b0;
            c_flag_q <= 1'b0;
        end else begin
            if (w_accept) begin
                op_q  <= w_op_in;
                rd_q  <= bus.instr[13:12];
                imm_q <= bus.instr[7:0];
                if (w_in_is_alu) begin
                    x_q   <= regs_q[bus.instr[11:10]];
                    y_q   <= regs_q[bus.instr[9:8]];
                    sel_q <= w_op_in[1];
                end
            end
            if (state_q == ST_EXEC) begin
                res_q   <= bus.data_out;
                cap_c_q <= bus.cnext;
            end
            if (state_q == ST_WB) begin
                if (op_q == OP_LOADI) begin
                    regs_q[rd_q] <= DW'(imm_q);
                end else if (w_op_is_alu) begin
                    regs_q[rd_q] <= res_q;
                    c_flag_q     <= cap_c_q;
                end
            end
        end
    end

    assign bus.instr_ready = (state_q == ST_IDLE);
    assign bus.done        = (state_q == ST_WB);
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.sel         = sel_q;
    assign bus.c_flag      = c_flag_q;
    assign bus.rd_data     = regs_q[bus.rd_sel];
endmodule
`default_nettype wire
